// File: rtl/alu_sched_pkg.sv
// Shared ISA definitions for alu_sched: ALU control codes and the default datapath width.
// Both the ALU and the scheduler import these, so no code value is defined twice.
package alu_sched_pkg;

   localparam int XLEN_DEFAULT = 32;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SRA  = 4'b1101;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;

   typedef enum logic {
      REQ_0 = 1'b0,
      REQ_1 = 1'b1
   } req_id_e;

endpackage

// File: rtl/alu_sched_alu.sv
// Purely combinational integer ALU shared by the alu_sched requesters.
// Shift amounts use the low log2(XLEN) bits of operand b.
module alu
   import alu_sched_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic [3:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic [XLEN-1:0] result_o,
   output logic            zero_o
);

   localparam int SHW = $clog2(XLEN);

   logic [SHW-1:0] shamt;
   assign shamt = b_i[SHW-1:0];

   // NOTE: assign a default before the case so every path drives result_o and no latch is inferred.
   always_comb begin
      result_o = '0;
      case (op_i)
         ALU_ADD:  result_o = a_i + b_i;
         ALU_SUB:  result_o = a_i - b_i;
         ALU_SLL:  result_o = a_i << shamt;
         ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
         ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, a_i < b_i};
         ALU_XOR:  result_o = a_i ^ b_i;
         ALU_SRL:  result_o = a_i >> shamt;
         ALU_SRA:  result_o = $signed(a_i) >>> shamt;
         ALU_OR:   result_o = a_i | b_i;
         ALU_AND:  result_o = a_i & b_i;
         default:  result_o = '0;
      endcase
   end

   assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_sched.sv
// Two-requester scheduler sharing one ALU, with a single registered response slot (latency 1).
// Define ALU_SCHED_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_sched
   import alu_sched_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      req_valid,
   output logic [1:0]      req_ready,
   input  logic [3:0]      req0_op,
   input  logic [XLEN-1:0] req0_a,
   input  logic [XLEN-1:0] req0_b,
   input  logic [3:0]      req1_op,
   input  logic [XLEN-1:0] req1_a,
   input  logic [XLEN-1:0] req1_b,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic            rsp_id,
   output logic [XLEN-1:0] rsp_result,
   output logic            rsp_zero
);

   req_id_e         gnt_id;
   logic            accept;
   logic            xfer;
   logic [3:0]      alu_op;
   logic [XLEN-1:0] alu_a, alu_b, alu_result;
   logic            alu_zero;

   logic            rsp_valid_q, rsp_valid_d;
   logic            rsp_id_q, rsp_id_d;
   logic [XLEN-1:0] rsp_result_q, rsp_result_d;
   logic            rsp_zero_q, rsp_zero_d;

`ifdef ALU_SCHED_RR_EN
   logic last_q, last_d;

   always_comb begin
      gnt_id = REQ_0;
      if (&req_valid) gnt_id = req_id_e'(~last_q);
      else if (req_valid[1]) gnt_id = REQ_1;
   end

   assign last_d = xfer ? gnt_id : last_q;

   // Reset to "requester 1 last" so the first contested grant goes to requester 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) last_q <= 1'b1;
      else     last_q <= last_d;
   end
`else
   assign gnt_id = (req_valid == 2'b10) ? REQ_1 : REQ_0;
`endif

   assign accept    = ~rsp_valid_q | rsp_ready;
   assign req_ready = (accept && |req_valid && !rst) ?
                      ((gnt_id == REQ_1) ? 2'b10 : 2'b01) : 2'b00;
   assign xfer      = |(req_valid & req_ready);

   assign alu_op = (gnt_id == REQ_1) ? req1_op : req0_op;
   assign alu_a  = (gnt_id == REQ_1) ? req1_a  : req0_a;
   assign alu_b  = (gnt_id == REQ_1) ? req1_b  : req0_b;

   alu #(.XLEN(XLEN)) u_alu (
      .op_i     (alu_op),
      .a_i      (alu_a),
      .b_i      (alu_b),
      .result_o (alu_result),
      .zero_o   (alu_zero)
   );

   always_comb begin
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_zero_d   = rsp_zero_q;
      if (xfer) begin
         rsp_valid_d  = 1'b1;
         rsp_id_d     = gnt_id;
         rsp_result_d = alu_result;
         rsp_zero_d   = alu_zero;
      end else if (rsp_ready) begin
         rsp_valid_d  = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   // NOTE: all response fields are reset, not just valid, because reset values are visible on ports.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
         rsp_zero_q   <= 1'b0;
      end else begin
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_zero_q   <= rsp_zero_d;
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_sched.sv
// Directed, table-driven bench for alu_sched; expected values are hand-computed constants.
// Arbitration expectations follow ALU_SCHED_RR_EN the same way the RTL build does.
module tb_alu_sched;
   import alu_sched_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  req_valid = 2'b00;
   logic [1:0]  req_ready;
   logic [3:0]  req0_op = '0, req1_op = '0;
   logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic        rsp_id;
   logic [31:0] rsp_result;
   logic        rsp_zero;

   int n_checks = 0;
   int n_errors = 0;

   alu_sched #(.XLEN(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req0_op    (req0_op),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_op    (req1_op),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_zero   (rsp_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        id;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_result;
      logic        exp_zero;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_rsp(input string name, input logic id, input logic [31:0] res,
                            input logic zero);
      check({name, ".valid"},  {31'b0, rsp_valid}, 32'd1);
      check({name, ".id"},     {31'b0, rsp_id},    {31'b0, id});
      check({name, ".result"}, rsp_result,         res);
      check({name, ".zero"},   {31'b0, rsp_zero},  {31'b0, zero});
   endtask

   initial begin
      vecs[0]  = '{1'b0, ALU_ADD,  32'd5,        32'd3,        32'd8,        1'b0};
      vecs[1]  = '{1'b1, ALU_SUB,  32'd0,        32'd5,        32'hFFFFFFFB, 1'b0};
      vecs[2]  = '{1'b0, ALU_XOR,  32'd1,        32'd1,        32'd0,        1'b1};
      vecs[3]  = '{1'b1, ALU_OR,   32'hF0,       32'h0F,       32'hFF,       1'b0};
      vecs[4]  = '{1'b0, ALU_AND,  32'hF0F0,     32'h0FF0,     32'h00F0,     1'b0};
      vecs[5]  = '{1'b1, ALU_SLL,  32'd1,        32'd4,        32'd16,       1'b0};
      vecs[6]  = '{1'b0, ALU_SRL,  32'h80000000, 32'd31,       32'd1,        1'b0};
      vecs[7]  = '{1'b1, ALU_SRA,  32'hFFFFFFF8, 32'd2,        32'hFFFFFFFE, 1'b0};
      vecs[8]  = '{1'b0, ALU_SLT,  32'hFFFFFFFF, 32'd1,        32'd1,        1'b0};
      vecs[9]  = '{1'b1, ALU_SLTU, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1};
      vecs[10] = '{1'b0, ALU_SLTU, 32'd1,        32'hFFFFFFFF, 32'd1,        1'b0};
      vecs[11] = '{1'b1, ALU_ADD,  32'hFFFFFFFF, 32'd1,        32'd0,        1'b1};

      // Reset state, with both requesters asking
      req_valid = 2'b11;
      tick();
      tick();
      check("reset.rsp_valid",  {31'b0, rsp_valid}, 32'd0);
      check("reset.rsp_id",     {31'b0, rsp_id},    32'd0);
      check("reset.rsp_result", rsp_result,         32'd0);
      check("reset.rsp_zero",   {31'b0, rsp_zero},  32'd0);
      check("reset.req_ready",  {30'b0, req_ready}, 32'd0);
      req_valid = 2'b00;
      rst = 1'b0;
      #1;

      // Single requests back-to-back from the table
      for (int i = 0; i < 12; i++) begin
         if (vecs[i].id) begin
            req1_op = vecs[i].op; req1_a = vecs[i].a; req1_b = vecs[i].b; req_valid = 2'b10;
         end else begin
            req0_op = vecs[i].op; req0_a = vecs[i].a; req0_b = vecs[i].b; req_valid = 2'b01;
         end
         #1;
         check($sformatf("vec%0d.req_ready", i), {30'b0, req_ready}, {30'b0, req_valid});
         tick();
         check_rsp($sformatf("vec%0d", i), vecs[i].id, vecs[i].exp_result, vecs[i].exp_zero);
      end
      req_valid = 2'b00;
      tick();
      check("idle.rsp_valid_clears", {31'b0, rsp_valid}, 32'd0);

      // Back-to-back stream from requester 0 with no bubble
      req0_op = ALU_SRA; req0_a = 32'hFFFFFFF8; req0_b = 32'd2; req_valid = 2'b01;
      tick();
      check_rsp("b2b.first", 1'b0, 32'hFFFFFFFE, 1'b0);
      req0_op = ALU_SLTU; req0_a = 32'hFFFFFFFF; req0_b = 32'd1;
      #1;
      check("b2b.req_ready", {30'b0, req_ready}, 32'd1);
      tick();
      check_rsp("b2b.second", 1'b0, 32'd0, 1'b1);
      req_valid = 2'b00;
      tick();

      // Backpressure: response held, requests refused, one response on release
      req1_op = ALU_SUB; req1_a = 32'd0; req1_b = 32'd5; req_valid = 2'b10;
      tick();
      rsp_ready = 1'b0;
      req_valid = 2'b01;
      for (int c = 0; c < 3; c++) begin
         #1;
         check($sformatf("bp%0d.req_ready", c), {30'b0, req_ready}, 32'd0);
         check_rsp($sformatf("bp%0d", c), 1'b1, 32'hFFFFFFFB, 1'b0);
         tick();
      end
      req_valid = 2'b00;
      rsp_ready = 1'b1;
      #1;
      check_rsp("bp.release", 1'b1, 32'hFFFFFFFB, 1'b0);
      tick();
      check("bp.after_release", {31'b0, rsp_valid}, 32'd0);
      tick();
      check("bp.no_second_rsp", {31'b0, rsp_valid}, 32'd0);

      // Single request, then asynchronous reset while the response is pending
      req0_op = ALU_ADD; req0_a = 32'd5; req0_b = 32'd3; req_valid = 2'b01;
      tick();
      check_rsp("single", 1'b0, 32'd8, 1'b0);
      req_valid = 2'b00;
      rsp_ready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("async_rst.rsp_valid",  {31'b0, rsp_valid}, 32'd0);
      check("async_rst.rsp_result", rsp_result,         32'd0);
      req0_op = ALU_XOR; req0_a = 32'd1;    req0_b = 32'd1;
      req1_op = ALU_OR;  req1_a = 32'hF0;   req1_b = 32'h0F;
      req_valid = 2'b11;
      rsp_ready = 1'b1;
      #1;
      check("async_rst.req_ready", {30'b0, req_ready}, 32'd0);
      tick();
      check("async_rst.no_xfer", {31'b0, rsp_valid}, 32'd0);
      rst = 1'b0;

      // Both requesters valid for 4 cycles; first grant after reset goes to requester 0
      for (int c = 0; c < 4; c++) begin
         logic exp_id;
`ifdef ALU_SCHED_RR_EN
         exp_id = c[0];
`else
         exp_id = 1'b0;
`endif
         #1;
         check($sformatf("arb%0d.req_ready", c), {30'b0, req_ready},
               exp_id ? 32'd2 : 32'd1);
         tick();
         check_rsp($sformatf("arb%0d", c), exp_id, exp_id ? 32'hFF : 32'd0, ~exp_id);
      end
      req_valid = 2'b00;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
